// File: rtl/ram_burst_reader.sv
// Burst read sequencer for a ram_1r1w_sync read port: one read per cycle, the 1-cycle
// read latency absorbed by a 2-entry skid FIFO, valid/ready output with a last-beat flag.
//   state    | meaning
//   st_idle  | waiting for a burst command
//   st_run   | issuing reads, returning beats
//   st_drain | all reads issued, emptying the skid buffer
module ram_burst_reader #(
  parameter int width_p = 8,
  parameter int depth_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [$clog2(depth_p)-1:0]   cmd_addr_i,
  input  logic [$clog2(depth_p+1)-1:0] cmd_len_i,
  output logic                         ram_rd_valid_o,
  output logic [$clog2(depth_p)-1:0]   ram_rd_addr_o,
  input  logic [width_p-1:0]           ram_rd_data_i,
  output logic                         data_valid_o,
  input  logic                         data_ready_i,
  output logic [width_p-1:0]           data_o,
  output logic                         data_last_o,
  output logic                         busy_o
);

  localparam int aw_lp = $clog2(depth_p);
  localparam int lw_lp = $clog2(depth_p+1);

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_run   = 2'd1;
  localparam logic [1:0] st_drain = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [aw_lp-1:0]   addr_q, addr_d;
  logic [lw_lp-1:0]   len_q, len_d;
  logic [lw_lp-1:0]   issued_q, issued_d;
  logic [lw_lp-1:0]   ret_q, ret_d;
  logic               inflight_q, inflight_d;
  logic [1:0]         occ_q, occ_d;
  logic [width_p-1:0] head_data_q, head_data_d;
  logic               head_last_q, head_last_d;
  logic [width_p-1:0] tail_data_q, tail_data_d;
  logic               tail_last_q, tail_last_d;

  logic pop, push, push_last, issue, room, cmd_fire;

  assign pop       = (occ_q != 2'd0) && data_ready_i;
  assign push      = inflight_q;
  assign push_last = (ret_q == len_q - lw_lp'(1));
  assign cmd_fire  = (state_q == st_idle) && cmd_valid_i;

  // occ + inflight - pop <= 1, rearranged to stay unsigned
  assign room  = (3'(occ_q) + 3'(inflight_q)) <= (3'd1 + 3'(pop));
  assign issue = (state_q == st_run) && (issued_q < len_q) && room;

  assign cmd_ready_o    = (state_q == st_idle);
  assign busy_o         = (state_q != st_idle);
  assign ram_rd_valid_o = issue;
  assign ram_rd_addr_o  = addr_q;
  assign data_valid_o   = (occ_q != 2'd0);
  assign data_o         = (occ_q != 2'd0) ? head_data_q : '0;
  assign data_last_o    = (occ_q != 2'd0) && head_last_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    ret_d      = ret_q + lw_lp'(push);
    inflight_d = issue;

    if (issue) begin
      addr_d   = (addr_q == aw_lp'(depth_p-1)) ? '0 : addr_q + aw_lp'(1);
      issued_d = issued_q + lw_lp'(1);
    end

    case (state_q)
      st_idle: begin
        if (cmd_fire && (cmd_len_i != '0)) begin
          addr_d   = cmd_addr_i;
          len_d    = cmd_len_i;
          issued_d = '0;
          ret_d    = '0;
          state_d  = st_run;
        end
      end
      st_run: begin
        if (pop && head_last_q)
          state_d = st_idle;
        else if (issue && (issued_q + lw_lp'(1) == len_q))
          state_d = st_drain;
      end
      st_drain: begin
        if (pop && head_last_q)
          state_d = st_idle;
      end
      default: state_d = st_idle;
    endcase
  end

  always_comb begin
    occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    case (occ_q)
      2'd0: begin
        if (push) begin
          head_data_d = ram_rd_data_i;
          head_last_d = push_last;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_data_d = ram_rd_data_i;
          head_last_d = push_last;
        end else if (push) begin
          tail_data_d = ram_rd_data_i;
          tail_last_d = push_last;
        end
      end
      default: begin
        // issue throttling guarantees no push into a full buffer without a pop
        if (pop) begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
          if (push) begin
            tail_data_d = ram_rd_data_i;
            tail_last_d = push_last;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= st_idle;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      ret_q       <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      ret_q       <= ret_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a behavioural 1-cycle-latency RAM (mem[i]=0x10+i).
module tb_ram_burst_reader;
  localparam int W = 8;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       rd_valid;
  logic [2:0] rd_addr;
  logic [W-1:0] rd_data;
  logic       dvalid;
  logic       dready;
  logic [W-1:0] data;
  logic       last;
  logic       busy;

  logic [W-1:0] mem [D];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_burst_reader #(.width_p(W), .depth_p(D)) dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .ram_rd_valid_o(rd_valid), .ram_rd_addr_o(rd_addr), .ram_rd_data_i(rd_data),
    .data_valid_o(dvalid), .data_ready_i(dready), .data_o(data),
    .data_last_o(last), .busy_o(busy)
  );

  always @(posedge clk) begin
    if (reset) rd_data <= '0;
    else if (rd_valid) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string tag, input int obs, input int want);
    total++;
    if (obs != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, want, $time);
    end
  endtask

  // Ready held high; cycle k=0 is the command handshake. Optionally a next command
  // is presented from cycle 1 onward and must wait until cycle len+3.
  task automatic burst(input int addr, input int len, input int nv, input int naddr, input int nlen);
    for (int k = 0; k <= len + 2; k++) begin
      if (k == 0) begin
        cmd_valid = 1'b1; cmd_addr = 3'(addr); cmd_len = 4'(len);
      end else if (k == 1) begin
        cmd_valid = nv[0]; cmd_addr = 3'(naddr); cmd_len = 4'(nlen);
      end
      dready = 1'b1;
      @(negedge clk);
      chk("cmd_ready", cmd_ready, k == 0);
      chk("busy", busy, k >= 1);
      chk("rd_valid", rd_valid, k >= 1 && k <= len);
      if (k >= 1 && k <= len) chk("rd_addr", rd_addr, (addr + k - 1) % D);
      chk("dvalid", dvalid, k >= 3);
      if (k >= 3) begin
        chk("data", data, 'h10 + (addr + k - 3) % D);
        chk("last", last, k == len + 2);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dvalid"}, dvalid, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    int pat [6];
    int occ, infl, issued, popped, pop, exp_rv;
    pat = '{1, 0, 0, 1, 0, 1};
    for (int i = 0; i < D; i++) mem[i] = 8'(8'h10 + i);
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; dready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_data", data, 0);
    chk("rst_last", last, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // basic burst, then wrap-around burst
    burst(2, 4, 0, 0, 0);
    idle_check("b1_end");
    burst(6, 5, 0, 0, 0);
    idle_check("wrap_end");

    // backpressure against a reference model of occupancy and in-flight reads
    cmd_valid = 1'b1; cmd_addr = 3'd0; cmd_len = 4'd6; dready = 1'b0;
    @(negedge clk);
    chk("bp_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    occ = 0; infl = 0; issued = 0; popped = 0;
    for (int k = 1; k < 60 && popped < 6; k++) begin
      dready = pat[k % 6][0];
      @(negedge clk);
      pop = (occ > 0 && dready) ? 1 : 0;
      exp_rv = (issued < 6 && (occ + infl - pop) <= 1) ? 1 : 0;
      chk("bp_busy", busy, 1);
      chk("bp_dvalid", dvalid, occ > 0);
      chk("bp_rd_valid", rd_valid, exp_rv);
      if (exp_rv != 0) chk("bp_rd_addr", rd_addr, issued);
      if (occ > 0) begin
        chk("bp_data", data, 'h10 + popped);
        chk("bp_last", last, popped == 5);
      end
      if (pop != 0) popped++;
      @(posedge clk); #1;
      occ = occ + infl - pop;
      infl = exp_rv;
      issued += exp_rv;
    end
    chk("bp_beats", popped, 6);
    dready = 1'b1;
    idle_check("bp_end");

    // zero-length command
    cmd_valid = 1'b1; cmd_addr = 3'd4; cmd_len = 4'd0;
    @(negedge clk);
    chk("z_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) idle_check("z");

    // full depth with second command held valid during the first burst
    burst(0, 8, 1, 3, 8);
    burst(3, 8, 0, 0, 0);
    idle_check("b2b_end");

    // reset during the second beat of a len=6 burst
    cmd_valid = 1'b1; cmd_addr = 3'd0; cmd_len = 4'd6; dready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(negedge clk);
    chk("mr_beat2_valid", dvalid, 1);
    chk("mr_beat2_data", data, 'h11);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mr_cmd_ready", cmd_ready, 1);
    chk("mr_rd_valid", rd_valid, 0);
    chk("mr_rd_addr", rd_addr, 0);
    chk("mr_dvalid", dvalid, 0);
    chk("mr_data", data, 0);
    chk("mr_last", last, 0);
    chk("mr_busy", busy, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) idle_check("mr_quiet");
    burst(5, 3, 0, 0, 0);
    idle_check("mr_fresh_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
